// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared constants and types for the EX/MEM pipeline stage.
// Control vectors are declared [0:CTRL_W-1], so bit 0 is the MSB.
package ex_mem_pkg;

  // Default widths for the stage parameters
  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;
  localparam int CTRL_W_DEF = 9;
  localparam int CNT_W_DEF  = 16;

  // Control vector bit positions (ascending index, bit 0 = MSB)
  localparam int MEMREAD_BIT  = 2;
  localparam int MEMWRITE_BIT = 4;
  localparam int REGWRITE_BIT = 6;
  localparam int WORD_BIT     = 8;

  // Decoded strobe bundle layout
  localparam int STRB_COUNT    = 4;
  localparam int STRB_MEMREAD  = 3;
  localparam int STRB_MEMWRITE = 2;
  localparam int STRB_REGWRITE = 1;
  localparam int STRB_WORD     = 0;

  // Entry layout at the default widths
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] store_data;
    logic [RD_W_DEF-1:0]   rd;
    logic [0:CTRL_W_DEF-1] ctrl;
  } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: main + skid entry pair with a registered ready.
// The skid entry catches one input while the main entry is stalled.
// Strobe bits are cleared whenever their entry becomes invalid.
// Data bits of an invalid entry keep their old value.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int ENTRY_W = 1,
  parameter int STRB_W  = STRB_COUNT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_data,
  input  logic [STRB_W-1:0]  in_strb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [STRB_W-1:0]  out_strb
);

  logic               main_valid_r, main_valid_s;
  logic [ENTRY_W-1:0] main_data_r,  main_data_s;
  logic [STRB_W-1:0]  main_strb_r,  main_strb_s;
  logic               skid_valid_r, skid_valid_s;
  logic [ENTRY_W-1:0] skid_data_r,  skid_data_s;
  logic [STRB_W-1:0]  skid_strb_r,  skid_strb_s;
  logic               accept_s;
  logic               main_free_s;

  // Next-state for both entries: flush first, then drain/refill, then skid capture
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    main_strb_s  = main_strb_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_strb_s  = skid_strb_r;
    accept_s     = in_valid && !skid_valid_r;
    main_free_s  = !main_valid_r || out_ready;
    if (flush) begin
      main_valid_s = 1'b0;
      main_strb_s  = {STRB_W{1'b0}};
      skid_valid_s = 1'b0;
      skid_strb_s  = {STRB_W{1'b0}};
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        // Skid moves up; a same-cycle input refills the skid slot
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        main_strb_s  = skid_strb_r;
        skid_valid_s = accept_s;
        if (accept_s) begin
          skid_data_s = in_data;
          skid_strb_s = in_strb;
        end else begin
          skid_strb_s = {STRB_W{1'b0}};
        end
      end else if (accept_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
        main_strb_s  = in_strb;
      end else begin
        main_valid_s = 1'b0;
        main_strb_s  = {STRB_W{1'b0}};
      end
    end else if (accept_s) begin
      // Main is stalled: park the incoming entry in the skid slot
      skid_valid_s = 1'b1;
      skid_data_s  = in_data;
      skid_strb_s  = in_strb;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Entry registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {ENTRY_W{1'b0}};
      main_strb_r  <= {STRB_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {ENTRY_W{1'b0}};
      skid_strb_r  <= {STRB_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      main_strb_r  <= main_strb_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_strb_r  <= skid_strb_s;
    end
  end

  assign in_ready  = !skid_valid_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign out_strb  = main_strb_r;

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline stage with valid/ready flow control,
// synchronous flush, registered memory/writeback strobes and a
// saturating stall counter.
// Build option: define EX_MEM_SKID_EN for a two-entry buffer with a
// registered inReady; otherwise a single entry with combinational inReady.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inResult,
  input  logic [DATA_W-1:0] inReadRegister2,
  input  logic [RD_W-1:0]   inRd,
  input  logic [0:CTRL_W-1] inControlBits,
  input  logic              flush,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outResult,
  output logic [DATA_W-1:0] outReadRegister2,
  output logic [RD_W-1:0]   outRd,
  output logic [0:CTRL_W-1] outControlBits,
  output logic              outMemRead,
  output logic              outMemWrite,
  output logic              outRegWrite,
  output logic              outWord,
  output logic [CNT_W-1:0]  stallCount
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [RD_W-1:0]   rd;
    logic [0:CTRL_W-1] ctrl;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Pull the memory/writeback strobes out of the control vector
  function automatic logic [STRB_COUNT-1:0] decode_strobes(input logic [0:CTRL_W-1] ctrl);
    logic [STRB_COUNT-1:0] strb;
    strb                = {STRB_COUNT{1'b0}};
    strb[STRB_MEMREAD]  = ctrl[MEMREAD_BIT];
    strb[STRB_MEMWRITE] = ctrl[MEMWRITE_BIT];
    strb[STRB_REGWRITE] = ctrl[REGWRITE_BIT];
    strb[STRB_WORD]     = ctrl[WORD_BIT];
    return strb;
  endfunction

  entry_t                in_entry_s;
  entry_t                out_entry_s;
  logic [ENTRY_W-1:0]    in_data_s;
  logic [ENTRY_W-1:0]    out_data_s;
  logic [STRB_COUNT-1:0] in_strb_s;
  logic [STRB_COUNT-1:0] out_strb_s;
  logic                  out_valid_s;
  logic                  in_ready_s;
  logic [CNT_W-1:0]      stall_cnt_r;

  // Pack incoming fields and decode their strobes
  always_comb begin
    in_entry_s.result     = inResult;
    in_entry_s.store_data = inReadRegister2;
    in_entry_s.rd         = inRd;
    in_entry_s.ctrl       = inControlBits;
    in_data_s             = in_entry_s;
    in_strb_s             = decode_strobes(inControlBits);
  end

`ifdef EX_MEM_SKID_EN
  ex_mem_skid #(
    .ENTRY_W(ENTRY_W),
    .STRB_W (STRB_COUNT)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (inValid),
    .in_ready (in_ready_s),
    .in_data  (in_data_s),
    .in_strb  (in_strb_s),
    .out_valid(out_valid_s),
    .out_ready(outReady),
    .out_data (out_data_s),
    .out_strb (out_strb_s)
  );
`else
  logic                  out_valid_r;
  logic [ENTRY_W-1:0]    out_data_r;
  logic [STRB_COUNT-1:0] out_strb_r;

  assign in_ready_s = !out_valid_r || outReady;

  // Single holding entry: flush kills, otherwise load whenever the stage can accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {ENTRY_W{1'b0}};
      out_strb_r  <= {STRB_COUNT{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_strb_r  <= {STRB_COUNT{1'b0}};
    end else if (in_ready_s) begin
      out_valid_r <= inValid;
      if (inValid) begin
        out_data_r <= in_data_s;
        out_strb_r <= in_strb_s;
      end else begin
        out_strb_r <= {STRB_COUNT{1'b0}};
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid_s = out_valid_r;
  assign out_data_s  = out_data_r;
  assign out_strb_s  = out_strb_r;
`endif

  // Saturating count of cycles the held entry waits on the memory stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_s && !outReady && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign out_entry_s      = entry_t'(out_data_s);
  assign inReady          = in_ready_s;
  assign outValid         = out_valid_s;
  assign outResult        = out_entry_s.result;
  assign outReadRegister2 = out_entry_s.store_data;
  assign outRd            = out_entry_s.rd;
  assign outControlBits   = out_entry_s.ctrl;
  assign outMemRead       = out_strb_s[STRB_MEMREAD];
  assign outMemWrite      = out_strb_s[STRB_MEMWRITE];
  assign outRegWrite      = out_strb_s[STRB_REGWRITE];
  assign outWord          = out_strb_s[STRB_WORD];
  assign stallCount       = stall_cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed self-checking bench for ex_mem_pipe (single-entry build).
// Stall counter is built 4 bits wide so saturation is reachable.
module tb_ex_mem_pipe;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset_n;
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inResult;
  logic [DATA_W-1:0] inReadRegister2;
  logic [RD_W-1:0]   inRd;
  logic [0:CTRL_W-1] inControlBits;
  logic              flush;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outResult;
  logic [DATA_W-1:0] outReadRegister2;
  logic [RD_W-1:0]   outRd;
  logic [0:CTRL_W-1] outControlBits;
  logic              outMemRead;
  logic              outMemWrite;
  logic              outRegWrite;
  logic              outWord;
  logic [CNT_W-1:0]  stallCount;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_pipe #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .inValid         (inValid),
    .inReady         (inReady),
    .inResult        (inResult),
    .inReadRegister2 (inReadRegister2),
    .inRd            (inRd),
    .inControlBits   (inControlBits),
    .flush           (flush),
    .outValid        (outValid),
    .outReady        (outReady),
    .outResult       (outResult),
    .outReadRegister2(outReadRegister2),
    .outRd           (outRd),
    .outControlBits  (outControlBits),
    .outMemRead      (outMemRead),
    .outMemWrite     (outMemWrite),
    .outRegWrite     (outRegWrite),
    .outWord         (outWord),
    .stallCount      (stallCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {outMemRead, outMemWrite, outRegWrite, outWord};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    inValid         = 1'b0;
    inResult        = 32'h0;
    inReadRegister2 = 32'h0;
    inRd            = 5'd0;
    inControlBits   = 9'b000000000;
    flush           = 1'b0;
    outReady        = 1'b1;
    #1;
    check("rst_valid", outValid, 32'd0);
    check("rst_strb", strobes(), 32'd0);
    check("rst_result", outResult, 32'd0);
    check("rst_stall", stallCount, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Streaming at full throughput
    inValid = 1'b1;
    #1;
    check("idle_ready", inReady, 32'd1);
    for (int i = 0; i < 3; i++) begin
      inResult = 32'h10 * (i + 1);
      tick();
      check("stream_valid", outValid, 32'd1);
      check("stream_result", outResult, 32'h10 * (i + 1));
    end

    // Strobe decode
    inResult = 32'h40; inRd = 5'd7; inReadRegister2 = 32'hCAFE;
    inControlBits = 9'b001010101;
    tick();
    check("dec_all_strb", strobes(), 32'hF);
    check("dec_rd", outRd, 32'd7);
    check("dec_store", outReadRegister2, 32'hCAFE);
    check("dec_ctrl", outControlBits, 32'h055);
    inResult = 32'h50; inControlBits = 9'b001000000;
    tick();
    check("dec_memread_only", strobes(), 32'h8);
    inValid = 1'b0;
    tick();
    check("bubble_valid", outValid, 32'd0);
    check("bubble_strb", strobes(), 32'd0);

    // Backpressure
    inValid = 1'b1; inResult = 32'h60; inControlBits = 9'b000010001;
    tick();
    check("bp_load", outResult, 32'h60);
    check("bp_stall0", stallCount, 32'd0);
    outReady = 1'b0; inResult = 32'h70;
    #1;
    check("bp_ready_low", inReady, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_result", outResult, 32'h60);
      check("bp_hold_strb", strobes(), 32'h5);
      check("bp_ready", inReady, 32'd0);
      check("bp_count", stallCount, i + 1);
    end
    outReady = 1'b1;
    #1;
    check("bp_ready_back", inReady, 32'd1);
    tick();
    check("bp_drain_result", outResult, 32'h70);
    check("bp_drain_valid", outValid, 32'd1);
    check("bp_count_kept", stallCount, 32'd5);

    // Flush collision with an offered input
    flush = 1'b1; inResult = 32'hDEAD;
    tick();
    check("fl_valid", outValid, 32'd0);
    check("fl_strb", strobes(), 32'd0);
    check("fl_no_dead", (outResult == 32'hDEAD), 32'd0);
    flush = 1'b0; inValid = 1'b0;
    tick();
    check("fl_after_valid", outValid, 32'd0);
    check("fl_after_no_dead", (outResult == 32'hDEAD), 32'd0);

    // Flush during a stall keeps the counter
    inValid = 1'b1; inResult = 32'h80;
    tick();
    outReady = 1'b0; inValid = 1'b0;
    tick();
    check("fls_count", stallCount, 32'd6);
    flush = 1'b1;
    tick();
    check("fls_valid", outValid, 32'd0);
    check("fls_count_kept", stallCount, 32'd7);
    flush = 1'b0; outReady = 1'b1;

    // Asynchronous reset in the middle of a stall
    inValid = 1'b1; inResult = 32'h90; inRd = 5'd3;
    tick();
    outReady = 1'b0;
    tick();
    check("pre_rst_valid", outValid, 32'd1);
    check("pre_rst_count", stallCount, 32'd8);
    reset_n = 1'b0;
    #2;
    check("arst_valid", outValid, 32'd0);
    check("arst_strb", strobes(), 32'd0);
    check("arst_result", outResult, 32'd0);
    check("arst_rd", outRd, 32'd0);
    check("arst_ctrl", outControlBits, 32'd0);
    check("arst_count", stallCount, 32'd0);
    tick();
    reset_n = 1'b1;

    // Saturation of the 4-bit counter
    outReady = 1'b1; inValid = 1'b1; inResult = 32'hA0;
    tick();
    outReady = 1'b0; inValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("sat_count", stallCount, (i + 1 > 15) ? 15 : i + 1);
    end
    check("sat_hold_result", outResult, 32'hA0);
    outReady = 1'b1;
    tick();
    check("sat_drained", outValid, 32'd0);
    check("sat_final", stallCount, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
